// File: rtl/mul11x11_pkg.sv
// Shared FPU definitions for the mantissa multiply/divide units.
package mul11x11_pkg;

  localparam int unsigned MW = 10;
  localparam logic HIDDEN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul11x11.sv
// Sequential shift-add mantissa multiplier: (1.f1) x (1.f2), one multiplier bit per cycle,
// returning a normalized MW+1 bit mantissa plus a normalize flag for the exponent logic.
module mul11x11 #(
  parameter int unsigned MW = mul11x11_pkg::MW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st,
  input  logic [MW-1:0] f1,
  input  logic [MW-1:0] f2,
  output logic          done,
  output logic [MW:0]   f,
  output logic          norm
);
  import mul11x11_pkg::*;

  localparam int unsigned AW = 2*MW + 3;
  localparam int unsigned CW = $clog2(MW + 2);

  state_t        state;
  logic [CW-1:0] count;
  logic [AW-1:0] acc;
  logic [MW:0]   mcand;
  logic          done_q;

  logic [MW+1:0] hi_sum;
  logic [AW-1:0] acc_step;

  // Upper MW+2 bits accumulate partial products with the carry kept,
  // lower MW+1 bits hold the multiplier and shift out as they are consumed.
  always_comb begin
    hi_sum   = acc[AW-1:MW+1] + (acc[0] ? {1'b0, mcand} : '0);
    acc_step = {1'b0, hi_sum, acc[MW:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (st) begin
            mcand <= {HIDDEN, f1};
            acc   <= {{(MW+1){1'b0}}, HIDDEN, f2};
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_step;
          count <= count + CW'(1);
          if (count == CW'(MW)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          if (st) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign done = done_q;

  always_comb begin
    f    = '0;
    norm = 1'b0;
    if (state == DONE) begin
      norm = acc[2*MW+1];
      f    = acc[2*MW+1] ? acc[2*MW+1:MW+1] : acc[2*MW:MW];
    end
  end

endmodule
